ecc_auth_ctrl_p: RTL and testbench

- Parametrised next-generation controller for the ECC authentication datapath.
- Collects the private key as ROM words and the basepoint as serial decoder bits, then sequences the ECC point-multiplier start/enable/done handshake.
- Adds over the previous generation:
  - internal key-word and basepoint-bit counting, so no external done-key strobe is needed;
  - a selectable step mode, including compute with a retained basepoint;
  - a compute watchdog with a sticky error flag.
- Sits between the command decoder / ROM fetch unit and the ECC core.

---
 rtl/ecc_auth_ctrl_p.sv | 170 +++++++++++++++++
 tb/tb_ecc_auth_ctrl_p.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_auth_ctrl_p.sv
// ecc_auth_ctrl_p: session controller for the ECC authentication datapath.
// Collects the private key (ROM words) and basepoint (serial decoder bits),
// then runs the start/enable/done handshake with the ECC point multiplier,
// guarded by a compute watchdog that raises a sticky error flag.
module ecc_auth_ctrl_p #(
    parameter int KEY_W    = 176,
    parameter int ROM_W    = 16,
    parameter int POINT_W  = 163,
    parameter int WDOG_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_time_up,
    input  logic               i_auth_shift,
    input  logic               i_data_dec,
    input  logic               i_auth_ok,
    input  logic [1:0]         i_auth_step,
    input  logic               i_key_shift,
    input  logic [ROM_W-1:0]   i_data_rom,
    input  logic               i_done_ecc,
    output logic               o_start_ecc,
    output logic               o_en_ecc,
    output logic               o_done_ecc,
    output logic               o_err,
    output logic               o_busy,
    output logic [KEY_W-1:0]   o_key,
    output logic [POINT_W-1:0] o_basepoint
);

    localparam int KEY_WORDS = KEY_W / ROM_W;
    localparam int KC_W      = $clog2(KEY_WORDS + 1);
    localparam int PC_W      = $clog2(POINT_W + 1);
    localparam int WD_W      = $clog2(WDOG_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_AUTH,
        S_READ_KEY,
        S_START,
        S_COMPUTE,
        S_FINISH,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [KC_W-1:0]    key_cnt_q, key_cnt_d;
    logic [PC_W-1:0]    pt_cnt_q, pt_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               err_q, err_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [POINT_W-1:0] bp_q, bp_d;

    logic key_full;
    logic key_take;
    logic pt_take;

    assign key_full = (key_cnt_q == KC_W'(KEY_WORDS));

    // Key words are accepted in any pre-compute state until the key is full;
    // the key stays frozen while the core is running.
    assign key_take = i_key_shift && !key_full &&
                      (state_q != S_START) && (state_q != S_COMPUTE);

    // Basepoint bits only load for step 1, during IDLE/READ_AUTH; extra bits
    // beyond POINT_W are discarded.
    assign pt_take = i_auth_shift && (i_auth_step == 2'd1) &&
                     ((state_q == S_IDLE) || (state_q == S_READ_AUTH)) &&
                     (pt_cnt_q < PC_W'(POINT_W));

    // Next-state, capture and counter logic; session timeout overrides the FSM.
    always_comb begin
        state_d   = state_q;
        key_cnt_d = key_cnt_q;
        pt_cnt_d  = pt_cnt_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        key_d     = key_q;
        bp_d      = bp_q;

        if (i_time_up) begin
            state_d   = S_IDLE;
            key_cnt_d = '0;
            pt_cnt_d  = '0;
        end else begin
            if (key_take) begin
                key_d     = {key_q[KEY_W-ROM_W-1:0], i_data_rom};
                key_cnt_d = key_cnt_q + KC_W'(1);
            end
            if (pt_take) begin
                bp_d     = {bp_q[POINT_W-2:0], i_data_dec};
                pt_cnt_d = pt_cnt_q + PC_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (i_auth_shift) begin
                        state_d = S_READ_AUTH;
                        err_d   = 1'b0;
                    end
                end
                S_READ_AUTH: begin
                    if (i_auth_ok) state_d = S_READ_KEY;
                end
                S_READ_KEY: begin
                    if (key_full) begin
                        case (i_auth_step)
                            2'd0:    state_d = S_FINISH;
                            2'd1,
                            2'd2:    state_d = S_START;
                            default: begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                S_START: begin
                    wdog_d  = '0;
                    state_d = S_COMPUTE;
                end
                S_COMPUTE: begin
                    wdog_d = wdog_q + WD_W'(1);
                    if (i_done_ecc) begin
                        state_d = S_FINISH;
                    end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                S_FINISH, S_ERR: begin
                    state_d   = S_IDLE;
                    key_cnt_d = '0;
                    pt_cnt_d  = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            key_cnt_q <= '0;
            pt_cnt_q  <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            key_q     <= '0;
            bp_q      <= '0;
        end else begin
            state_q   <= state_d;
            key_cnt_q <= key_cnt_d;
            pt_cnt_q  <= pt_cnt_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            key_q     <= key_d;
            bp_q      <= bp_d;
        end
    end

    // Moore output decode.
    assign o_start_ecc = (state_q == S_START);
    assign o_en_ecc    = (state_q == S_START) || (state_q == S_COMPUTE);
    assign o_done_ecc  = (state_q == S_FINISH);
    assign o_err       = err_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_key       = key_q;
    assign o_basepoint = bp_q;

endmodule

// File: tb/tb_ecc_auth_ctrl_p.sv
// Self-checking bench for ecc_auth_ctrl_p: a default-parameter instance
// checked through a start/done event scoreboard, plus a WDOG_CYC=8 instance
// sharing the same stimulus for the watchdog scenario.
module tb_ecc_auth_ctrl_p;

    localparam int KEY_W     = 176;
    localparam int ROM_W     = 16;
    localparam int POINT_W   = 163;
    localparam int KEY_WORDS = KEY_W / ROM_W;
    localparam logic [7:0] EV_S = 8'h53;
    localparam logic [7:0] EV_D = 8'h44;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_time_up, i_auth_shift, i_data_dec, i_auth_ok;
    logic [1:0]         i_auth_step;
    logic               i_key_shift;
    logic [ROM_W-1:0]   i_data_rom;
    logic               i_done_ecc;

    logic               o_start_ecc, o_en_ecc, o_done_ecc, o_err, o_busy;
    logic [KEY_W-1:0]   o_key;
    logic [POINT_W-1:0] o_basepoint;

    logic               w_start, w_en, w_done, w_err, w_busy;
    logic [KEY_W-1:0]   w_key;
    logic [POINT_W-1:0] w_bp;

    ecc_auth_ctrl_p dut (
        .clk(clk), .rst(rst), .i_time_up(i_time_up), .i_auth_shift(i_auth_shift),
        .i_data_dec(i_data_dec), .i_auth_ok(i_auth_ok), .i_auth_step(i_auth_step),
        .i_key_shift(i_key_shift), .i_data_rom(i_data_rom), .i_done_ecc(i_done_ecc),
        .o_start_ecc(o_start_ecc), .o_en_ecc(o_en_ecc), .o_done_ecc(o_done_ecc),
        .o_err(o_err), .o_busy(o_busy), .o_key(o_key), .o_basepoint(o_basepoint)
    );

    ecc_auth_ctrl_p #(.WDOG_CYC(8)) dut_w (
        .clk(clk), .rst(rst), .i_time_up(i_time_up), .i_auth_shift(i_auth_shift),
        .i_data_dec(i_data_dec), .i_auth_ok(i_auth_ok), .i_auth_step(i_auth_step),
        .i_key_shift(i_key_shift), .i_data_rom(i_data_rom), .i_done_ecc(i_done_ecc),
        .o_start_ecc(w_start), .o_en_ecc(w_en), .o_done_ecc(w_done),
        .o_err(w_err), .o_busy(w_busy), .o_key(w_key), .o_basepoint(w_bp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]         kind;
        logic [KEY_W-1:0]   key;
        logic [POINT_W-1:0] bp;
    } ev_t;

    ev_t                sb_q[$];
    ev_t                mon_e;
    logic [KEY_W-1:0]   key_m;
    logic [POINT_W-1:0] bp_m;
    int n_chk = 0, n_err = 0;
    int start_cnt, done_cnt, en_cnt, w_en_cnt;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        start_cnt = 0; done_cnt = 0; en_cnt = 0; w_en_cnt = 0;
    endtask

    task automatic push_ev(input logic [7:0] kind);
        ev_t e;
        e.kind = kind; e.key = key_m; e.bp = bp_m;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every start/done pulse of the main instance must match the
    // next expected event, carrying the expected key and basepoint.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_en_ecc)    en_cnt++;
            if (w_en)        w_en_cnt++;
            if (o_start_ecc) start_cnt++;
            if (o_done_ecc)  done_cnt++;
            if (o_start_ecc || o_done_ecc) begin
                chk("sb_pending", 256'(sb_q.size() > 0), 256'(1));
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    chk("sb_kind", o_start_ecc ? EV_S : EV_D, mon_e.kind);
                    chk("sb_key", o_key, mon_e.key);
                    chk("sb_bp", o_basepoint, mon_e.bp);
                end
            end
        end
    end

    task automatic idle_inputs();
        i_time_up = 0; i_auth_shift = 0; i_data_dec = 0; i_auth_ok = 0;
        i_auth_step = 0; i_key_shift = 0; i_data_rom = 0; i_done_ecc = 0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1;
        tick();
        chk({tag, "_ctl"}, {o_start_ecc, o_en_ecc, o_done_ecc, o_err, o_busy}, 0);
        chk({tag, "_key"}, o_key, 0);
        chk({tag, "_bp"}, o_basepoint, 0);
        chk({tag, "_werr"}, w_err, 0);
        rst = 0;
        key_m = '0; bp_m = '0;
        tick();
    endtask

    // Drive basepoint bits, the auth header and key words; update the models.
    task automatic front(input int step, input int nbits, input logic [7:0] pat,
                         input int nwords, input logic [15:0] wbase);
        logic b;
        logic [15:0] w;
        i_auth_step = 2'(step);
        for (int k = 0; k < nbits; k++) begin
            b = pat[7 - (k % 8)];
            i_auth_shift = 1; i_data_dec = b;
            if (step == 1 && k < POINT_W) bp_m = {bp_m[POINT_W-2:0], b};
            tick();
        end
        i_auth_shift = 0; i_data_dec = 0; i_auth_ok = 1;
        tick();
        i_auth_ok = 0;
        for (int k = 0; k < nwords; k++) begin
            w = wbase + 16'(k);
            i_key_shift = 1; i_data_rom = w;
            if (k < KEY_WORDS) key_m = {key_m[KEY_W-ROM_W-1:0], w};
            tick();
        end
        i_key_shift = 0; i_data_rom = 0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!o_start_ecc && n < 50) begin
            tick();
            n++;
        end
        chk("start_timeout", o_start_ecc, 1);
    endtask

    task automatic compute(input int done_at);
        repeat (done_at) tick();
        i_done_ecc = 1;
        tick();
        i_done_ecc = 0;
        repeat (3) tick();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        key_m = '0; bp_m = '0;
        clr_cnt();
        tick();
        do_reset("reset");

        // Full compute, step 1, done 20 cycles after start.
        clr_cnt();
        front(1, POINT_W, 8'h5A, KEY_WORDS, 16'h0001);
        push_ev(EV_S); push_ev(EV_D);
        wait_start();
        compute(20);
        chk("t1_start_cnt", start_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_en_cyc", en_cnt, 21);
        chk("t1_err", o_err, 0);
        chk("t1_key", o_key, 176'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B);
        chk("t1_bp", o_basepoint, bp_m);

        // Key only with one extra word.
        clr_cnt();
        front(0, 1, 8'hFF, KEY_WORDS + 1, 16'h0020);
        push_ev(EV_D);
        repeat (5) tick();
        chk("t2_start_cnt", start_cnt, 0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_key", o_key, key_m);
        chk("t2_bp", o_basepoint, bp_m);

        // Step 2 with different basepoint bits: retained basepoint.
        clr_cnt();
        front(2, POINT_W, 8'hA5, KEY_WORDS, 16'h0040);
        push_ev(EV_S); push_ev(EV_D);
        wait_start();
        compute(10);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_en_cyc", en_cnt, 11);
        chk("t3_bp", o_basepoint, bp_m);

        // Time-up in compute cycle 5, together with done.
        clr_cnt();
        front(1, POINT_W, 8'h3C, KEY_WORDS, 16'h0060);
        push_ev(EV_S);
        wait_start();
        repeat (5) tick();
        i_time_up = 1; i_done_ecc = 1;
        tick();
        i_time_up = 0; i_done_ecc = 0;
        chk("t4_busy", o_busy, 0);
        chk("t4_en", o_en_ecc, 0);
        repeat (3) tick();
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_key", o_key, key_m);
        chk("t4_bp", o_basepoint, bp_m);
        // A fresh key-only session must need all words again.
        front(0, 1, 8'h00, KEY_WORDS, 16'h0080);
        push_ev(EV_D);
        repeat (5) tick();
        chk("t4_done2_cnt", done_cnt, 1);
        chk("t4_key2", o_key, key_m);

        // Reset while in READ_KEY with six words captured.
        clr_cnt();
        front(1, 1, 8'h80, 6, 16'h0090);
        chk("t5_busy_pre", o_busy, 1);
        do_reset("t5_rst");
        front(0, 1, 8'h00, KEY_WORDS, 16'h00A0);
        push_ev(EV_D);
        repeat (5) tick();
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_key", o_key, key_m);

        // Watchdog on the WDOG_CYC=8 instance.
        do_reset("t6_rst");
        clr_cnt();
        front(1, POINT_W, 8'hC3, KEY_WORDS, 16'h00B0);
        push_ev(EV_S);
        wait_start();
        repeat (8) tick();
        chk("t6_err_pre", w_err, 0);
        chk("t6_en_last", w_en, 1);
        tick();
        chk("t6_err_set", w_err, 1);
        chk("t6_err_busy", w_busy, 1);
        tick();
        chk("t6_idle_busy", w_busy, 0);
        repeat (3) tick();
        chk("t6_err_hold", w_err, 1);
        i_auth_step = 0; i_auth_shift = 1;
        tick();
        i_auth_shift = 0;
        chk("t6_err_clr", w_err, 0);
        chk("t6_readauth", w_busy, 1);
        chk("t6_en_cyc", w_en_cnt, 9);
        do_reset("t6_end");

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
